btn_ctrl: RTL
=============

BTN_CTRL -- requirements
Module: btn_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CNT, default 100000, meaning the number of consecutive stable cycles needed to accept a level change (1 ms at 100 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (rst=0 resets on a rising clk edge).
REQ-004 The block SHALL have port addr, input, 32 bits: bus address; only addr[3:2] is decoded, and the base address is decoded outside the block.
REQ-005 The block SHALL have port we, input, 1 bit: bus write strobe, single cycle.
REQ-006 The block SHALL have port wdata, input, 32 bits: bus write data.
REQ-007 The block SHALL have port button, input, 5 bits: raw asynchronous push-button levels, 1 = pressed.
REQ-008 The block SHALL have port rdata, output, 32 bits: combinational read data for the current addr.
REQ-009 The block SHALL have port irq, output, 1 bit: interrupt request, level, active-high.

Function
REQ-010 Each button bit SHALL pass through a 2-flop synchronizer (sync2) before any use.
REQ-011 Each bit SHALL have an independent debounce counter of width $clog2(DB_CNT+1) and a stable level bit STATE[i].
REQ-012 The counter SHALL reset to 0 in any cycle where sync2[i]==STATE[i], and increment otherwise.
REQ-013 When sync2[i]!=STATE[i] and the counter equals DB_CNT-1, STATE[i] SHALL toggle at that edge and the counter SHALL clear.
REQ-014 A raw level held constant SHALL reach STATE exactly 2+DB_CNT rising edges after it first meets setup; a glitch shorter than DB_CNT cycles SHALL never change STATE.
REQ-015 The counter SHALL never wrap; it saturates behaviour-wise via REQ-013 clear.
REQ-016 A press event for bit i SHALL be the edge where STATE[i] goes 0->1; release (1->0) SHALL generate no event.
REQ-017 The register map SHALL be addr[3:2]=0 STATE (read-only, rdata[4:0]=STATE, upper bits 0).
REQ-018 The register map SHALL be addr[3:2]=1 EVENT (sticky press flags [4:0]); writing 1 to a bit clears it and writing 0 has no effect.
REQ-019 The register map SHALL be addr[3:2]=2 CTRL (bit0 = irq enable, read/write, other bits read 0).
REQ-020 The register map SHALL be addr[3:2]=3 LAST (read-only code of the most recent press).
REQ-021 The LAST codes SHALL be: bit0 32'h11111111, bit1 32'h22222222, bit2 32'h44444444, bit3 32'h88888888, bit4 32'hffffffff, none 32'h0.
REQ-022 If several bits see a press event at the same edge, EVENT SHALL set all of them and LAST SHALL take the highest index.
REQ-023 If a press-set and a W1C-clear hit the same EVENT bit at the same edge, the set SHALL win (bit reads 1 afterwards).
REQ-024 Writes to the STATE and LAST addresses SHALL be ignored.
REQ-025 Write effects SHALL be visible on rdata in the cycle after the write edge.
REQ-026 irq SHALL be combinational: CTRL[0] & |EVENT, with no extra latency beyond the registers.
REQ-027 rdata SHALL be purely combinational from addr and registers, with zero read latency and no read side effects.

Reset
REQ-028 On reset, sync2, STATE, all counters, EVENT and CTRL SHALL be 0 and LAST SHALL be 32'h0, so irq=0 and rdata=0 for every addr.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count; after release, a held button SHALL require the full 2+DB_CNT edges again.
REQ-030 Reset SHALL take priority over any simultaneous write or event.

Verification (DB_CNT=4)
REQ-031 Hold button=5'b00100 from cycle 0 -> STATE reads 32'h4 after edge 6 and not before; EVENT=32'h4; LAST=32'h44444444.
REQ-032 Pulse button[0] high for 3 cycles, then low -> STATE, EVENT and LAST remain 0 throughout.
REQ-033 Write CTRL=1, press button[1] until debounced -> irq rises in the cycle after STATE[1] sets; write EVENT=32'h2 -> irq=0 next cycle.
REQ-034 Debounce button[0] and button[4] on the same edge -> EVENT=32'h11 and LAST=32'hffffffff; writing EVENT=32'h1 in the same cycle as a new button[0] press event -> EVENT[0] stays 1.
REQ-035 Assert rst=0 for one edge while button[3] is mid-count (count=2) with EVENT and CTRL nonzero -> all reads are 0 and irq=0; the held button debounces 6 edges after rst=1.
REQ-036 Write 32'hffffffff to STATE and to LAST -> both are unchanged; CTRL reads back 32'h1.

Source files
------------

// File: rtl/btn_ctrl.sv
// Five-button controller with a memory-mapped register interface.
// Each raw button bit is synchronised with two flops and then debounced. A
// debounced 0->1 transition is a press: it sets a sticky EVENT flag (write 1
// to clear), updates the LAST press code and can raise a level interrupt.
module btn_ctrl #(
    parameter int DB_CNT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [4:0]  button,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int CW = $clog2(DB_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

    typedef enum logic [1:0] {
        REG_STATE = 2'd0,
        REG_EVENT = 2'd1,
        REG_CTRL  = 2'd2,
        REG_LAST  = 2'd3
    } reg_sel_e;

    reg_sel_e      sel;
    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    state;
    logic [CW-1:0] cnt [5];
    logic [4:0]    flip;
    logic [4:0]    press;
    logic [4:0]    evt;
    logic [4:0]    evt_clr;
    logic          ctrl_en;
    logic [31:0]   last;
    logic [31:0]   last_code;

    // Only addr[3:2] and the low data bits take part in decoding.
    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:5]};

    assign sel = reg_sel_e'(addr[3:2]);

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // A bit flips once it has disagreed with STATE for DB_CNT edges; a press is a rising flip.
    always_comb begin
        flip  = '0;
        press = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            flip[i]  = (sync2[i] != state[i]) && (cnt[i] == CNT_LAST);
            press[i] = flip[i] && sync2[i];
        end
    end

    // Per-bit debounce counter and stable level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2[i] == state[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    state[i] <= ~state[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Press code, later bits override earlier so the highest index wins.
    always_comb begin
        last_code = '0;
        if (press[0]) last_code = 32'h11111111;
        if (press[1]) last_code = 32'h22222222;
        if (press[2]) last_code = 32'h44444444;
        if (press[3]) last_code = 32'h88888888;
        if (press[4]) last_code = 32'hffffffff;
    end

    assign evt_clr = (we && (sel == REG_EVENT)) ? wdata[4:0] : '0;

    // Sticky event flags (set beats clear), control register and last press code.
    always_ff @(posedge clk) begin
        if (!rst) begin
            evt     <= '0;
            ctrl_en <= 1'b0;
            last    <= '0;
        end else begin
            evt <= (evt & ~evt_clr) | press;
            if (we && (sel == REG_CTRL)) begin
                ctrl_en <= wdata[0];
            end
            if (|press) begin
                last <= last_code;
            end
        end
    end

    // Zero-latency read mux.
    always_comb begin
        rdata = '0;
        case (sel)
            REG_STATE: rdata = {27'd0, state};
            REG_EVENT: rdata = {27'd0, evt};
            REG_CTRL:  rdata = {31'd0, ctrl_en};
            REG_LAST:  rdata = last;
            default:   rdata = '0;
        endcase
    end

    assign irq = ctrl_en & (|evt);

endmodule
